// File: rtl/fifo_rd_arbiter_if.sv
// Read-side arbiter bundle: FIFO read ports plus
// the valid/ready output stream and status.
interface fifo_rd_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 3,
  parameter int CW = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]        empty;
  logic [NUM_CH*DATA_W-1:0] fifo_data;
  logic [NUM_CH-1:0]        r_en;
  logic [DATA_W-1:0]        m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic [CW-1:0]            m_ch;
  logic                     m_last;
  logic                     busy;

  modport master (
    input  empty,
    input  fifo_data,
    input  m_ready,
    output r_en,
    output m_data,
    output m_valid,
    output m_ch,
    output m_last,
    output busy
  );

  modport slave (
    output empty,
    output fifo_data,
    output m_ready,
    input  r_en,
    input  m_data,
    input  m_valid,
    input  m_ch,
    input  m_last,
    input  busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst reader draining NUM_CH FIFOs
// into a 2-entry credit-checked output buffer.
module fifo_rd_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 3,
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  fifo_rd_arbiter_if.master bus
);
  localparam int CW = $clog2(NUM_CH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     g_q, g_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        occ_q, occ_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic [DATA_W-1:0] dat_q [2];
  logic [DATA_W-1:0] dat_d [2];
  logic [CW-1:0]     ch_q [2];
  logic [CW-1:0]     ch_d [2];
  logic              last_q [2];
  logic              last_d [2];

  logic              pop, push, push_last;
  logic              credit_ok, rd, rd_last;
  logic              found;
  logic [CW-1:0]     pick, g_nxt;
  logic [1:0]        occ_p;
  logic [DATA_W-1:0] word;
  logic [NUM_CH-1:0] r_en_c;
  int                idx;

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    occ_d       = occ_q;
    dat_d       = dat_q;
    ch_d        = ch_q;
    last_d      = last_q;
    found       = 1'b0;
    pick        = '0;
    idx         = 0;
    r_en_c      = '0;

    pop = (occ_q != 2'd0) && bus.m_ready;
    credit_ok = (int'(occ_q) + int'(infl_q)
                 - int'(pop)) < 2;
    rd = (state_q == BURST) && !bus.empty[g_q]
         && credit_ok;
    rd_last = (cnt_q == 4'(BURST_LEN - 1));
    g_nxt = (g_q == CW'(NUM_CH - 1)) ? '0
            : g_q + CW'(1);
    if (rd) r_en_c[g_q] = 1'b1;

    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_q) + k) % NUM_CH;
      if (!found && !bus.empty[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          g_d     = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (rd) begin
          cnt_d = cnt_q + 4'd1;
          if (rd_last) begin
            state_d = IDLE;
            rr_d    = g_nxt;
          end
        end else if (bus.empty[g_q] && !infl_q) begin
          state_d = IDLE;
          rr_d    = g_nxt;
        end
      end
      default: state_d = IDLE;
    endcase

    infl_d      = rd;
    infl_last_d = rd && rd_last;

    // Late last-tag: FIFO ran dry right behind the word in flight
    push      = infl_q;
    push_last = infl_last_q
                | ((state_q == BURST) && bus.empty[g_q]);
    word      = bus.fifo_data[int'(g_q)*DATA_W +: DATA_W];

    occ_p = occ_q - {1'b0, pop};
    if (pop) begin
      dat_d[0]  = dat_q[1];
      ch_d[0]   = ch_q[1];
      last_d[0] = last_q[1];
    end
    if (push) begin
      if (occ_p == 2'd0) begin
        dat_d[0]  = word;
        ch_d[0]   = g_q;
        last_d[0] = push_last;
      end else begin
        dat_d[1]  = word;
        ch_d[1]   = g_q;
        last_d[1] = push_last;
      end
    end
    occ_d = occ_p + {1'b0, push};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      occ_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        dat_q[i]  <= '0;
        ch_q[i]   <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      occ_q       <= occ_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      dat_q       <= dat_d;
      ch_q        <= ch_d;
      last_q      <= last_d;
    end
  end

  assign bus.r_en    = r_en_c;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_data  = dat_q[0];
  assign bus.m_ch    = ch_q[0];
  assign bus.m_last  = last_q[0];
  assign bus.busy    = (state_q == BURST);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench: FIFO models feed the arbiter,
// a monitor logs reads and accepted words.
module tb_fifo_rd_arbiter;
  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 3;
  localparam int BURST_LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W)
  ) bus ();

  fifo_rd_arbiter #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DATA_W-1:0] mem [NUM_CH][64];
  int                wr [NUM_CH] = '{default: 0};
  int                rd [NUM_CH] = '{default: 0};
  logic [DATA_W-1:0] fd [NUM_CH] = '{default: '0};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      bus.empty[i] = (rd[i] == wr[i]);
      bus.fifo_data[i*DATA_W +: DATA_W] = fd[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.r_en[i]) begin
        fd[i] <= mem[i][rd[i]];
        rd[i] <= rd[i] + 1;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  int cyc = 0;
  int first_v = -1;
  int q_d [$];
  int q_c [$];
  int q_l [$];
  int ren_cyc [$];
  int ren_ch [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) begin
        q_d.push_back(int'(bus.m_data));
        q_c.push_back(int'(bus.m_ch));
        q_l.push_back(int'(bus.m_last));
      end
      if (bus.m_valid && first_v < 0) first_v = cyc;
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.r_en[i]) begin
          ren_cyc.push_back(cyc);
          ren_ch.push_back(i);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(int c, int v);
    mem[c][wr[c]] = DATA_W'(v);
    wr[c] = wr[c] + 1;
  endtask

  task automatic clear_logs();
    q_d.delete();
    q_c.delete();
    q_l.delete();
    ren_cyc.delete();
    ren_ch.delete();
    first_v = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_r_en", int'(bus.r_en), 0);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_m_data", int'(bus.m_data), 0);
    check("rst_m_ch", int'(bus.m_ch), 0);
    check("rst_m_last", int'(bus.m_last), 0);
    tick(3);
    rst = 1'b0;
    clear_logs();
    #1;
    check("rel_r_en", int'(bus.r_en), 0);
    check("rel_busy", int'(bus.busy), 0);
  endtask

  task automatic drain(int n, string tag);
    int t = 0;
    while (q_d.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    tick(8);
    check({tag, "_count"}, q_d.size(), n);
  endtask

  task automatic expect_word(string tag, int i,
                             int d, int c, int l);
    if (i < q_d.size()) begin
      check({tag, "_data"}, q_d[i], d);
      check({tag, "_ch"}, q_c[i], c);
      check({tag, "_last"}, q_l[i], l);
    end else begin
      check({tag, "_missing"}, i, -1);
    end
  endtask

  initial begin
    int k;
    int t;
    int hold;
    bus.m_ready = 1'b1;

    // Reset held while every channel has data
    for (int c = 0; c < NUM_CH; c++) load(c, c + 1);
    apply_reset();
    drain(4, "rst_drain");
    for (int i = 0; i < 4; i++)
      expect_word("rst_w", i, i + 1, i, 1);

    // Single channel, six words
    apply_reset();
    for (int v = 1; v <= 6; v++) load(2, v);
    drain(6, "single");
    for (int i = 0; i < 6; i++)
      expect_word("single_w", i, i + 1, 2,
                  (i == 3 || i == 5) ? 1 : 0);
    check("single_nren", ren_cyc.size(), 6);
    if (ren_cyc.size() == 6) begin
      check("single_gap0", ren_cyc[3] - ren_cyc[0], 3);
      check("single_gap1", ren_cyc[4] - ren_cyc[3], 2);
      check("single_gap2", ren_cyc[5] - ren_cyc[4], 1);
      check("single_lat", first_v - ren_cyc[0], 2);
    end

    // Round-robin over all channels
    apply_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int v = 0; v < 8; v++) load(c, v);
    drain(32, "rr");
    for (int i = 0; i < 32; i++)
      expect_word("rr_w", i, (i / 16) * 4 + i % 4,
                  (i / 4) % 4, (i % 4 == 3) ? 1 : 0);

    // Backpressure
    apply_reset();
    bus.m_ready = 1'b0;
    for (int v = 0; v < 8; v++) load(0, (v + 1) & 7);
    tick(5);
    hold = int'(bus.m_data);
    check("bp_hold5", hold, 1);
    tick(5);
    check("bp_nren", ren_cyc.size(), 2);
    check("bp_valid", int'(bus.m_valid), 1);
    check("bp_stable", int'(bus.m_data), hold);
    bus.m_ready = 1'b1;
    drain(8, "bp");
    for (int i = 0; i < 8; i++)
      expect_word("bp_w", i, (i + 1) & 7, 0,
                  (i == 3 || i == 7) ? 1 : 0);

    // Early termination
    apply_reset();
    load(1, 5);
    for (int v = 1; v <= 5; v++) load(3, v);
    drain(6, "early");
    expect_word("early_w", 0, 5, 1, 1);
    for (int i = 1; i < 6; i++)
      expect_word("early_w", i, i, 3,
                  (i == 4 || i == 5) ? 1 : 0);

    // Reset mid-burst
    apply_reset();
    for (int v = 0; v < 8; v++) load(0, (v + 1) & 7);
    for (int v = 0; v < 3; v++) load(2, 6);
    k = 0;
    t = 0;
    while (k < 2 && t < 100) begin
      @(negedge clk);
      #1;
      if (bus.r_en[0]) k++;
      t++;
    end
    check("mid_reached", k, 2);
    rst = 1'b1;
    #1;
    check("mid_r_en", int'(bus.r_en), 0);
    check("mid_valid", int'(bus.m_valid), 0);
    check("mid_busy", int'(bus.busy), 0);
    tick(2);
    rst = 1'b0;
    clear_logs();
    drain(10, "mid");
    if (ren_ch.size() > 0)
      check("mid_first_ch", ren_ch[0], 0);
    else
      check("mid_no_read", 0, 1);
    expect_word("mid_w", 0, 2, 0, 0);
    expect_word("mid_w", 4, 6, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Read-side round-robin scheduler that drains NUM_CH async FIFO instances into one output stream. All logic runs in the shared read clock domain.
- Each FIFO gets a burst of up to BURST_LEN words per grant. The block drives each FIFO's r_en from that FIFO's empty flag and a credit check.
- A 2-entry output buffer with valid/ready handshake feeds the downstream encoder input stage.

Parameters:
- NUM_CH, 4, number of FIFO read ports arbitrated (2..8).
- DATA_W, 3, word width; equals the FIFO data width.
- BURST_LEN, 4, maximum words read per grant (1..15).

Ports:
- clk  in  1  read-domain clock; same clock as every attached FIFO clk_r.
- rst  in  1  reset, asynchronous, active-high.
- empty  in  NUM_CH  per-FIFO empty flag; bit i belongs to FIFO i.
- fifo_data  in  NUM_CH*DATA_W  FIFO data_out buses; FIFO i occupies bits [i*DATA_W +: DATA_W].
- r_en  out  NUM_CH  per-FIFO read enable; one-hot or zero.
- m_data  out  DATA_W  output word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the word.
- m_ch  out  $clog2(NUM_CH)  source channel of m_data.
- m_last  out  1  m_data is the final word of its burst.
- busy  out  1  state is BURST.

Behaviour:
FIFO contract:
- A read issued with r_en[i]=1 at cycle t presents the word on fifo_data[i] during t+1.
- empty[i] is valid for same-cycle r_en decisions.

Reset:
- Outputs: r_en=0, m_valid=0, m_data=0, m_ch=0, m_last=0, busy=0.
- Internal: state=IDLE, rr_ptr=0, burst_cnt=0, buffer occupancy 0, in-flight flag 0.

State IDLE:
- Search channels rr_ptr, rr_ptr+1, ... mod NUM_CH for the first with empty=0.
- If one is found: register it as grant g, clear burst_cnt, go to BURST next cycle.
- If none is found: stay IDLE.
- No r_en is issued in IDLE.

State BURST:
- r_en[g] = !empty[g] && credit_ok. This is combinational, so full throughput of one read per cycle is possible.
- credit_ok = (occ + inflight - pop) < 2, where pop = m_valid && m_ready.
- Each issued read increments burst_cnt.
- The read is tagged is_last=1 when burst_cnt+1 == BURST_LEN, or when empty[g] is observed 1 in the following cycle. In the second case, is_last is applied to the in-flight word.
- Go to IDLE when:
  - the BURST_LEN-th read is issued, or
  - empty[g]=1 with no read in flight or issued this cycle.
  On either exit, rr_ptr <= (g+1) mod NUM_CH.
- Credit stall (credit_ok=0): stay in BURST and hold burst_cnt.

Capture and output:
- A word in flight is captured at the end of cycle t+1 into the output buffer, together with its g and is_last tag.
- m_valid = occ>0. m_data, m_ch and m_last come from the head entry.
- The head is held stable while m_valid && !m_ready.
- A push and a pop in the same cycle are allowed. Occupancy never exceeds 2, and words are never dropped or duplicated.

Latency:
- empty[g] falls at cycle t with the block IDLE: BURST at t+1, r_en at t+1, m_valid at t+3.

Boundary cases:
- Granted channel empties mid-burst: the burst ends early and the last delivered word carries m_last=1.
- A zero-word burst (channel empties between grant and first read) produces no output and still advances rr_ptr.
- Reset asserted mid-burst: all outputs clear immediately (async). In-flight and buffered words are discarded. After release, search restarts at channel 0.

Test Plan:
- Reset: hold rst=1 with empty=4'b0000 -> r_en=0, m_valid=0, busy=0 throughout; first r_en no earlier than 2 cycles after release.
- Single channel: ch2 holds words 1..6, others empty, m_ready=1 -> r_en[2] pulses 4 consecutive cycles, then after IDLE 2 more. Output 1,2,3,4,5,6 with m_ch=2 and m_last=1 on words 4 and 6. First m_valid 3 cycles after BURST entry minus 1.
- Round-robin: all 4 channels hold 8 words, m_ready=1 -> grant order 0,1,2,3,0,1,2,3; m_last on every 4th word; 32 words out, in order per channel.
- Backpressure: ch0 holds 8 words, m_ready=0 for 10 cycles -> exactly 2 r_en pulses, m_data stable and m_valid=1. After m_ready=1, words 1..8 appear with no gap or duplicate.
- Early termination: ch1 holds 1 word, ch3 holds 5 words -> ch1 word with m_last=1, then ch3 4 words (m_last on 4th), then 1 word (m_last=1). rr_ptr ends at 0.
- Reset mid-burst: assert rst during ch0 read 2 of 4 -> r_en and m_valid drop in the same cycle. After release, with ch0 and ch2 non-empty, ch0 is granted first.
